// File: rtl/up_counter8b_pkg.sv
// Shared definitions for the up-counter family: data width, FSM state
// encodings and small compare helpers.
package up_counter8b_pkg;

    localparam int unsigned CNT_W = 8;

    // State encodings are shared by every counter in the family.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_HALT  = 2'b10
    } cnt_state_e;

    function automatic logic at_limit(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] lim
    );
        return cnt == lim;
    endfunction

endpackage

// File: rtl/full_adder8b.sv
// Ripple-carry adder, CNT_W bits wide, built from per-bit full-adder equations.
module full_adder8b
    import up_counter8b_pkg::*;
(
    input  logic [CNT_W-1:0] A,
    input  logic [CNT_W-1:0] B,
    input  logic             Cin,
    output logic [CNT_W-1:0] S,
    output logic             Cout
);

    logic [CNT_W:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < int'(CNT_W); i++) begin : g_bit
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[CNT_W];

endmodule

// File: rtl/incrementer8b.sv
// A + 1 with carry-out; Cout flags the natural FF -> 00 overflow.
module incrementer8b
    import up_counter8b_pkg::*;
(
    input  logic [CNT_W-1:0] A,
    output logic [CNT_W-1:0] S,
    output logic             Cout
);

    full_adder8b u_fa (
        .A    (A),
        .B    (CNT_W'(0)),
        .Cin  (1'b1),
        .S    (S),
        .Cout (Cout)
    );

endmodule

// File: rtl/up_counter8b.sv
// 8-bit up counter with load/clear, programmable terminal count and
// wrap-or-halt behaviour at the limit. All outputs come straight from flops.
module up_counter8b
    import up_counter8b_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] Q,
    output logic             Carry,
    output logic             Done,
    output logic             busy
);

    cnt_state_e       state_q, state_d;
    logic [CNT_W-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] inc_sum;
    logic             inc_cout;

    incrementer8b u_inc (
        .A    (q_q),
        .S    (inc_sum),
        .Cout (inc_cout)
    );

    // State and output registers; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state / next-output logic, priority clr > load > en > hold.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        carry_d = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            q_d     = '0;
        end else if (load) begin
            state_d = en ? ST_COUNT : ST_IDLE;
            q_d     = load_val;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (at_limit(q_q, limit)) begin
                        if (WRAP) begin
                            q_d     = '0;
                            carry_d = 1'b1;
                        end else begin
                            state_d = ST_HALT;
                        end
                    end else begin
                        // A count loaded above the limit overflows naturally.
                        q_d     = inc_sum;
                        carry_d = inc_cout;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                    q_d     = '0;
                end
            endcase
        end

        done_d = (state_d == ST_HALT);
        busy_d = (state_d == ST_COUNT);
    end

    assign Q     = q_q;
    assign Carry = carry_q;
    assign Done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_up_counter8b.sv
// Table-driven bench for up_counter8b: a WRAP=1 and a WRAP=0 instance share
// stimulus; each vector names the instance whose outputs it checks.
module tb_up_counter8b;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic [7:0] limit;

    logic [7:0] q1, q0;
    logic       carry1, carry0;
    logic       done1, done0;
    logic       busy1, busy0;

    int tests = 0;
    int fails = 0;

    up_counter8b #(.WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .limit(limit), .Q(q1), .Carry(carry1), .Done(done1), .busy(busy1)
    );

    up_counter8b #(.WRAP(1'b0)) dut_halt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .limit(limit), .Q(q0), .Carry(carry0), .Done(done0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic       rst_n;
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic [7:0] lim;
        logic [7:0] q;
        logic       c;
        logic       d;
        logic       b;
    } vec_t;

    typedef struct {
        int         idx;
        logic       w;
        logic [10:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    function automatic vec_t v(
        input logic w, input logic rn, input logic cl, input logic ld,
        input logic [7:0] lv, input logic e, input logic [7:0] lim,
        input logic [7:0] q, input logic c, input logic d, input logic b
    );
        vec_t r;
        r.w = w; r.rst_n = rn; r.clr = cl; r.load = ld; r.lv = lv;
        r.en = e; r.lim = lim; r.q = q; r.c = c; r.d = d; r.b = b;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    initial begin
        sb_t        e;
        logic [10:0] got;
        int         n;
        int         pulses;
        logic       seen;

        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; limit = 8'h05;

        // WRAP=1: reset then count 0..5 and wrap
        vecs.push_back(v(1,0,0,0,8'h00,0,8'h05, 8'h00,0,0,0));
        vecs.push_back(v(1,0,0,0,8'h00,0,8'h05, 8'h00,0,0,0));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h00,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h01,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h02,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h03,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h04,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h05,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h00,1,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h01,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,0,8'h05, 8'h01,0,0,0));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h01,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h02,0,0,1));
        // load above limit: natural overflow
        vecs.push_back(v(1,1,0,1,8'hFE,1,8'h10, 8'hFE,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h10, 8'hFF,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h10, 8'h00,1,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h10, 8'h01,0,0,1));
        // priority clr > load > en
        vecs.push_back(v(1,1,1,1,8'h55,1,8'h10, 8'h00,0,0,0));
        vecs.push_back(v(1,1,0,1,8'h55,1,8'h10, 8'h55,0,0,1));
        vecs.push_back(v(1,1,0,1,8'h33,0,8'h10, 8'h33,0,0,0));
        // limit = 0 with wrap
        vecs.push_back(v(1,1,1,0,8'h00,0,8'h00, 8'h00,0,0,0));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h00, 8'h00,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h00, 8'h00,1,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h00, 8'h00,1,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h00, 8'h00,1,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h00, 8'h00,1,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,0,8'h00, 8'h00,0,0,0));
        // reset kills a pending carry
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h00, 8'h00,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h00, 8'h00,1,0,1));
        vecs.push_back(v(1,0,0,0,8'h00,1,8'h00, 8'h00,0,0,0));
        // reset mid-count at 0x7A
        vecs.push_back(v(1,1,0,1,8'h78,1,8'hFF, 8'h78,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'hFF, 8'h79,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'hFF, 8'h7A,0,0,1));
        vecs.push_back(v(1,0,0,0,8'h00,1,8'hFF, 8'h00,0,0,0));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'hFF, 8'h00,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'hFF, 8'h01,0,0,1));
        // limit changes mid-count, used on the very next compare
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h02, 8'h02,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h02, 8'h00,1,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h01, 8'h01,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h05, 8'h02,0,0,1));
        vecs.push_back(v(1,1,0,0,8'h00,1,8'h02, 8'h00,1,0,1));
        // WRAP=0: count to 3 and halt
        vecs.push_back(v(0,0,0,0,8'h00,0,8'h03, 8'h00,0,0,0));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h03, 8'h00,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h03, 8'h01,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h03, 8'h02,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h03, 8'h03,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h03, 8'h03,0,1,0));
        vecs.push_back(v(0,1,0,0,8'h00,0,8'h03, 8'h03,0,1,0));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h03, 8'h03,0,1,0));
        vecs.push_back(v(0,1,0,0,8'h00,0,8'h03, 8'h03,0,1,0));
        vecs.push_back(v(0,1,0,1,8'h10,0,8'h03, 8'h10,0,0,0));
        // overflow above limit still wraps when halting is selected
        vecs.push_back(v(0,1,0,1,8'hFF,1,8'h10, 8'hFF,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h10, 8'h00,1,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h10, 8'h01,0,0,1));
        // halt exits via clr, load and reset
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h02, 8'h02,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h02, 8'h02,0,1,0));
        vecs.push_back(v(0,1,1,0,8'h00,1,8'h02, 8'h00,0,0,0));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h00, 8'h00,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h00, 8'h00,0,1,0));
        vecs.push_back(v(0,1,0,1,8'h20,1,8'h00, 8'h20,0,0,1));
        vecs.push_back(v(0,1,0,0,8'h00,1,8'h20, 8'h20,0,1,0));
        vecs.push_back(v(0,0,0,0,8'h00,1,8'h20, 8'h00,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rst_n;
            clr      = vecs[i].clr;
            load     = vecs[i].load;
            load_val = vecs[i].lv;
            en       = vecs[i].en;
            limit    = vecs[i].lim;
            e.idx = i;
            e.w   = vecs[i].w;
            e.exp = {vecs[i].q, vecs[i].c, vecs[i].d, vecs[i].b};
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            got = e.w ? {q1, carry1, done1, busy1} : {q0, carry0, done0, busy0};
            check($sformatf("vec%0d_wrap%0d {Q,Carry,Done,busy}", e.idx, e.w),
                  32'(got), 32'(e.exp));
        end

        // Wrap with limit 3 from a clean clear: first carry after 5 edges.
        rst_n = 1'b1; clr = 1'b1; load = 1'b0; en = 1'b0; limit = 8'h03;
        @(posedge clk);
        #1;
        clr = 1'b0; en = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = carry1;
        end
        check("first_carry_seen", 32'(seen), 32'd1);
        check("first_carry_latency", 32'(n), 32'd5);
        check("first_carry_q", 32'(q1), 32'h00);

        // Limit 7 for 64 enabled edges: one carry per 8 edges.
        limit = 8'h07;
        pulses = 0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (carry1) pulses++;
        end
        check("carry_pulses_64", 32'(pulses), 32'd8);
        check("q_after_64", 32'(q1), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/up_counter8b.md
UP_COUNTER8B -- requirements
Module: up_counter8b

Interface
REQ-001 Parameter: WRAP, default 1, 1 = wrap to 0 at limit, 0 = halt at limit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 clr  input  1  synchronous clear of count and state.
REQ-005 load  input  1  load load_val into count.
REQ-006 load_val  input  8  value for load.
REQ-007 en  input  1  count enable.
REQ-008 limit  input  8  terminal count value, sampled every cycle.
REQ-009 Q  output  8  registered count value.
REQ-010 Carry  output  1  registered one-cycle pulse on wrap to 0.
REQ-011 Done  output  1  registered level, high while in HALT.
REQ-012 busy  output  1  registered level, high while in COUNT.

Function
REQ-013 The FSM SHALL have three states: IDLE, COUNT, HALT.
REQ-014 Per-edge priority SHALL be: rst_n low > clr > load > en > hold.
REQ-015 clr=1 SHALL set Q=0, Carry=0, Done=0, state=IDLE, from any state.
REQ-016 load=1 SHALL set Q=load_val, Carry=0, state=COUNT if en=1 else IDLE, from any state, including HALT.
REQ-017 In IDLE with en=1, the next state SHALL be COUNT with no count change on that edge.
REQ-018 In COUNT with en=1 and Q!=limit, Q SHALL become Q+1 mod 256 on the next edge (latency 1).
REQ-019 In COUNT with en=1 and Q==limit, WRAP=1: Q becomes 0, Carry=1 for exactly one cycle, state stays COUNT.
REQ-020 In COUNT with en=1 and Q==limit, WRAP=0: Q is held, state becomes HALT, Done=1.
REQ-021 In COUNT with en=1, Q=8'hFF and limit!=8'hFF (count loaded above limit): Q becomes 0 and Carry pulses; no halt.
REQ-022 In COUNT with en=0, Q SHALL hold and the state SHALL become IDLE.
REQ-023 In HALT, Q SHALL hold regardless of en; HALT exits only via clr, load or reset.
REQ-024 Carry SHALL be 0 on every cycle not described in REQ-019/REQ-021.
REQ-025 The increment SHALL be computed by the incrementer sub-module, A+1 with carry-out; no behavioural "+" operator on Q.
REQ-026 A limit change mid-count SHALL take effect on the next compare; no latching.
REQ-027 limit=0 with WRAP=1 SHALL produce Q held at 0 with Carry high every enabled cycle.

Reset
REQ-028 With rst_n=0 at a rising edge: Q=8'h00, Carry=0, Done=0, busy=0, state=IDLE.
REQ-029 Reset mid-count or in HALT SHALL abort immediately with no residual Carry pulse.
REQ-030 No asynchronous paths; all outputs remain stable between edges.

Structure
REQ-031 State encodings (IDLE=2'b00, COUNT=2'b01, HALT=2'b10) SHALL be defined in a shared include file common to the counter family.
REQ-032 Sub-module incrementer8b SHALL be used (outputs S[7:0], Cout; input A[7:0]), built on full_adder8b with B=8'h00 and Cin=1.
REQ-033 Sub-module Cout SHALL drive the natural-overflow detection for REQ-021.

Verification
REQ-034 rst_n=0 for 2 cycles, then en=1 with limit=8'h05, WRAP=1 -> Q sequence 0,1,2,3,4,5,0; Carry high only in the cycle Q=0 after 5.
REQ-035 WRAP=0, limit=8'h03, en=1 from Q=0 -> Q 0,1,2,3 then held at 3; Done=1, busy=0; en toggling keeps Q=3; load=1 with load_val=8'h10 -> Q=16, Done=0.
REQ-036 load_val=8'hFE, limit=8'h10, en=1 -> Q FE,FF,00,01; Carry pulses once at 00.
REQ-037 Same edge with clr=1, load=1, en=1 -> Q=0, state IDLE; same edge with load=1, en=1 -> Q=load_val, busy=1.
REQ-038 rst_n=0 asserted while Q=8'h7A in COUNT -> next edge Q=0, Carry=0, Done=0, busy=0; count resumes from 0 only after en=1 in IDLE, plus one cycle.
REQ-039 limit=0, WRAP=1, en=1 for 4 cycles -> Q=0 throughout, Carry=1 on each enabled COUNT cycle.
